trigger_capture: RTL and testbench

TRIGGER_CAPTURE -- requirements
Module: trigger_capture

---
 rtl/trigger_capture.sv | 152 +++++++++++++++
 tb/tb_trigger_capture.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_capture.sv
// rtl/trigger_capture.sv - pre/post-trigger ADC sample capture into a circular RAM
// Streams samples to an external RAM and latches where the trigger and oldest sample landed.
module trigger_capture #(
   parameter int DATA_SIZE = 12,
   parameter int ADDR_SIZE = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 sample_valid_i,
   input  logic [DATA_SIZE-1:0] sample_i,
   input  logic                 arm_i,
   input  logic                 force_i,
   input  logic [DATA_SIZE-1:0] trig_level_i,
   input  logic                 trig_rising_i,
   input  logic [ADDR_SIZE-1:0] pretrig_i,
   output logic                 w_en_o,
   output logic [ADDR_SIZE-1:0] w_addr_o,
   output logic [DATA_SIZE-1:0] w_data_o,
   output logic [ADDR_SIZE-1:0] trig_addr_o,
   output logic [ADDR_SIZE-1:0] start_addr_o,
   output logic                 busy_o,
   output logic                 done_o
);

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

   localparam logic [ADDR_SIZE:0] CNT_N   = {1'b1, {ADDR_SIZE{1'b0}}};
   localparam logic [ADDR_SIZE:0] CNT_ONE = {{ADDR_SIZE{1'b0}}, 1'b1};

   state_t               state_q, state_d;
   logic [ADDR_SIZE-1:0] ptr_q, ptr_d;
   logic [ADDR_SIZE:0]   cnt_q, cnt_d;
   logic [ADDR_SIZE-1:0] pre_q, pre_d;
   logic [DATA_SIZE-1:0] prev_q, prev_d;
   logic                 prev_vld_q, prev_vld_d;
   logic                 force_q, force_d;
   logic                 w_en_q, w_en_d;
   logic [ADDR_SIZE-1:0] w_addr_q, w_addr_d;
   logic [DATA_SIZE-1:0] w_data_q, w_data_d;
   logic [ADDR_SIZE-1:0] trig_addr_q, trig_addr_d;
   logic [ADDR_SIZE-1:0] start_addr_q, start_addr_d;

   logic                 active;
   logic                 edge_hit;
   logic [ADDR_SIZE:0]   cnt_inc;
   logic [ADDR_SIZE:0]   post_target;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         ptr_q        <= '0;
         cnt_q        <= '0;
         pre_q        <= '0;
         prev_q       <= '0;
         prev_vld_q   <= 1'b0;
         force_q      <= 1'b0;
         w_en_q       <= 1'b0;
         w_addr_q     <= '0;
         w_data_q     <= '0;
         trig_addr_q  <= '0;
         start_addr_q <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         cnt_q        <= cnt_d;
         pre_q        <= pre_d;
         prev_q       <= prev_d;
         prev_vld_q   <= prev_vld_d;
         force_q      <= force_d;
         w_en_q       <= w_en_d;
         w_addr_q     <= w_addr_d;
         w_data_q     <= w_data_d;
         trig_addr_q  <= trig_addr_d;
         start_addr_q <= start_addr_d;
      end
   end

   // The first sample after arm only seeds prev, so no edge can fire on it.
   always_comb begin
      active      = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
      cnt_inc     = cnt_q + CNT_ONE;
      post_target = CNT_N - {1'b0, pre_q};
      if (trig_rising_i)
         edge_hit = prev_vld_q && (prev_q < trig_level_i) && (sample_i >= trig_level_i);
      else
         edge_hit = prev_vld_q && (prev_q > trig_level_i) && (sample_i <= trig_level_i);

      state_d      = state_q;
      ptr_d        = ptr_q;
      cnt_d        = cnt_q;
      pre_d        = pre_q;
      prev_d       = prev_q;
      prev_vld_d   = prev_vld_q;
      force_d      = force_q;
      w_en_d       = 1'b0;
      w_addr_d     = w_addr_q;
      w_data_d     = w_data_q;
      trig_addr_d  = trig_addr_q;
      start_addr_d = start_addr_q;

      if (arm_i) begin
         pre_d      = pretrig_i;
         ptr_d      = '0;
         cnt_d      = '0;
         prev_vld_d = 1'b0;
         force_d    = 1'b0;
         state_d    = (pretrig_i == '0) ? S_WAIT : S_PRE;
      end else begin
         if ((state_q == S_WAIT) && force_i)
            force_d = 1'b1;
         if (active && sample_valid_i) begin
            w_en_d     = 1'b1;
            w_addr_d   = ptr_q;
            w_data_d   = sample_i;
            ptr_d      = ptr_q + 1'b1;
            prev_d     = sample_i;
            prev_vld_d = 1'b1;
            case (state_q)
               S_PRE: begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == {1'b0, pre_q})
                     state_d = S_WAIT;
               end
               S_WAIT: begin
                  if (edge_hit || force_i || force_q) begin
                     trig_addr_d  = ptr_q;
                     start_addr_d = ptr_q - pre_q;
                     cnt_d        = CNT_ONE;
                     force_d      = 1'b0;
                     state_d      = (post_target == CNT_ONE) ? S_DONE : S_POST;
                  end
               end
               S_POST: begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == post_target)
                     state_d = S_DONE;
               end
               default: ;
            endcase
         end
      end
   end

   assign w_en_o       = w_en_q;
   assign w_addr_o     = w_addr_q;
   assign w_data_o     = w_data_q;
   assign trig_addr_o  = trig_addr_q;
   assign start_addr_o = start_addr_q;
   assign busy_o       = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
   assign done_o       = (state_q == S_DONE);

endmodule

// File: tb/tb_trigger_capture.sv
// tb/tb_trigger_capture.sv - self-checking bench for trigger_capture
// Directed table cases, hand-written corner sequences and randomized runs against an event-level model.
module tb_trigger_capture;

   localparam int DW = 12;
   localparam int AW = 4;
   localparam int N  = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          sample_valid;
   logic [DW-1:0] sample;
   logic          arm;
   logic          force_trig;
   logic [DW-1:0] trig_level;
   logic          trig_rising;
   logic [AW-1:0] pretrig;
   logic          w_en;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_data;
   logic [AW-1:0] trig_addr;
   logic [AW-1:0] start_addr;
   logic          busy;
   logic          done;

   always #5 clk = ~clk;

   trigger_capture #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) dut (
      .clk_i(clk), .rst_i(rst), .sample_valid_i(sample_valid), .sample_i(sample),
      .arm_i(arm), .force_i(force_trig), .trig_level_i(trig_level), .trig_rising_i(trig_rising),
      .pretrig_i(pretrig), .w_en_o(w_en), .w_addr_o(w_addr), .w_data_o(w_data),
      .trig_addr_o(trig_addr), .start_addr_o(start_addr), .busy_o(busy), .done_o(done)
   );

   int checks = 0;
   int errors = 0;
   int wr_count = 0;

   // Model works on sample counts since arm rather than FSM states.
   int m_armed, m_p, m_nw, m_trig, m_tidx, m_hprev, m_prev, m_fpend, m_done;
   int e_wen, e_waddr, e_wdata, e_taddr, e_saddr;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_armed = 0; m_p = 0; m_nw = 0; m_trig = 0; m_tidx = 0;
      m_hprev = 0; m_prev = 0; m_fpend = 0; m_done = 0;
      e_wen = 0; e_waddr = 0; e_wdata = 0; e_taddr = 0; e_saddr = 0;
   endtask

   task automatic model_step();
      int waiting, hit, cur, lvl;
      e_wen = 0;
      if (arm) begin
         m_armed = 1; m_p = int'(pretrig); m_nw = 0; m_trig = 0;
         m_hprev = 0; m_fpend = 0; m_done = 0;
         return;
      end
      if (m_armed == 0 || m_done != 0) return;
      waiting = (m_trig == 0 && m_nw >= m_p) ? 1 : 0;
      if (waiting != 0 && force_trig) m_fpend = 1;
      if (sample_valid) begin
         cur = int'(sample);
         lvl = int'(trig_level);
         e_wen = 1; e_waddr = m_nw % N; e_wdata = cur;
         if (waiting != 0) begin
            hit = m_fpend;
            if (m_hprev != 0) begin
               if (trig_rising && m_prev < lvl && cur >= lvl) hit = 1;
               if (!trig_rising && m_prev > lvl && cur <= lvl) hit = 1;
            end
            if (hit != 0) begin
               m_trig = 1; m_tidx = m_nw; m_fpend = 0;
               e_taddr = m_nw % N;
               e_saddr = (m_nw - m_p) % N;
            end
         end
         m_hprev = 1; m_prev = cur; m_nw++;
         if (m_trig != 0 && (m_nw - m_tidx) == N - m_p) m_done = 1;
      end
   endtask

   task automatic compare_all();
      check("w_en", int'(w_en), e_wen);
      check("w_addr", int'(w_addr), e_waddr);
      check("w_data", int'(w_data), e_wdata);
      check("trig_addr", int'(trig_addr), e_taddr);
      check("start_addr", int'(start_addr), e_saddr);
      check("busy", int'(busy), (m_armed != 0 && m_done == 0) ? 1 : 0);
      check("done", int'(done), m_done);
   endtask

   task automatic cycle();
      @(posedge clk);
      if (!rst) model_step();
      @(negedge clk);
      compare_all();
      if (w_en) wr_count++;
   endtask

   task automatic do_arm(input int p, input int lvl, input bit rising);
      arm = 1'b1; pretrig = AW'(p); trig_level = DW'(lvl); trig_rising = rising;
      sample_valid = 1'b0; force_trig = 1'b0;
      cycle();
      arm = 1'b0;
      wr_count = 0;
   endtask

   typedef struct {
      int p; int level; bit rising; int start; int step; int force_after;
      int exp_taddr; int exp_saddr; int exp_total;
   } vec_t;

   initial begin
      vec_t vecs[3];
      int k, forced, val, base;
      vecs[0] = '{4,   10, 1'b1,   0,  1, -1, 10, 6, 22};
      vecs[1] = '{0,    5, 1'b0,   9, -1, -1,  4, 4, 20};
      vecs[2] = '{2,  100, 1'b1, 100,  0, 20,  4, 2, 34};

      rst = 1'b1; arm = 1'b0; sample_valid = 1'b0; sample = '0; force_trig = 1'b0;
      trig_level = '0; trig_rising = 1'b1; pretrig = '0;
      model_reset();
      repeat (2) @(negedge clk);
      compare_all();
      rst = 1'b0;
      sample_valid = 1'b1; sample = 12'd33;
      repeat (3) cycle();

      for (int v = 0; v < 3; v++) begin
         do_arm(vecs[v].p, vecs[v].level, vecs[v].rising);
         k = 0; forced = 0;
         for (int c = 0; c < 120 && !done; c++) begin
            if (vecs[v].force_after >= 0 && k == vecs[v].force_after && forced == 0) begin
               sample_valid = 1'b0; force_trig = 1'b1; forced = 1;
            end else begin
               val = vecs[v].start + vecs[v].step * k;
               if (val < 0) val = 0;
               sample_valid = 1'b1; sample = DW'(val); force_trig = 1'b0; k++;
            end
            cycle();
         end
         sample_valid = 1'b0; force_trig = 1'b0;
         check("vec_done", int'(done), 1);
         check("vec_trig_addr", int'(trig_addr), vecs[v].exp_taddr);
         check("vec_start_addr", int'(start_addr), vecs[v].exp_saddr);
         check("vec_total_writes", wr_count, vecs[v].exp_total);
         sample_valid = 1'b1;
         repeat (3) cycle();
         check("vec_idle_writes", wr_count, vecs[v].exp_total);
         sample_valid = 1'b0;
      end

      // Re-arm while in POST with a simultaneous sample.
      do_arm(3, 10, 1'b1);
      for (int i = 0; i < 12; i++) begin
         sample_valid = 1'b1; sample = DW'(i);
         cycle();
      end
      check("post_reached", int'(busy && m_trig != 0 && m_done == 0), 1);
      arm = 1'b1; sample_valid = 1'b1; sample = 12'd55; pretrig = 4'd3;
      cycle();
      arm = 1'b0;
      check("rearm_no_write", int'(w_en), 0);
      check("rearm_done_low", int'(done), 0);
      check("rearm_busy", int'(busy), 1);
      sample = 12'd7;
      cycle();
      check("rearm_addr0", int'(w_addr), 0);
      check("rearm_data", int'(w_data), 7);

      // Asynchronous reset between edges while waiting for a trigger.
      do_arm(1, 4000, 1'b1);
      for (int i = 0; i < 5; i++) begin
         sample_valid = 1'b1; sample = DW'(i);
         cycle();
      end
      check("wait_busy", int'(busy), 1);
      #2 rst = 1'b1;
      #1;
      check("rst_w_en", int'(w_en), 0);
      check("rst_w_addr", int'(w_addr), 0);
      check("rst_w_data", int'(w_data), 0);
      check("rst_trig_addr", int'(trig_addr), 0);
      check("rst_start_addr", int'(start_addr), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      model_reset();
      cycle();
      rst = 1'b0;
      wr_count = 0;
      repeat (6) cycle();
      check("rst_no_writes", wr_count, 0);

      // Randomized captures, including live level changes, stray arms and resets.
      for (int r = 0; r < 30; r++) begin
         if ($urandom_range(0, 5) == 0) begin
            #2 rst = 1'b1;
            #1 model_reset();
            @(negedge clk);
            compare_all();
            rst = 1'b0;
         end
         base = $urandom_range(0, 4000);
         do_arm($urandom_range(0, N - 1), base + 8, 1'($urandom_range(0, 1)));
         for (int c = 0; c < 70; c++) begin
            sample_valid = ($urandom_range(0, 3) != 0);
            sample = DW'(base + $urandom_range(0, 16));
            force_trig = ($urandom_range(0, 39) == 0);
            arm = ($urandom_range(0, 149) == 0);
            pretrig = AW'($urandom_range(0, N - 1));
            if ($urandom_range(0, 19) == 0) begin
               trig_rising = 1'($urandom_range(0, 1));
               trig_level = DW'(base + $urandom_range(0, 16));
            end
            cycle();
         end
         arm = 1'b0; force_trig = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
